fp_mult_arbiter: RTL
====================

# fp_mult_arbiter

Round-robin scheduler that shares one pipelined single-precision FP multiplier (1–4 stages, no stall input) among NUM_REQ requesters. Each requester uses a valid/ready handshake to issue an operand pair. The block tags every issued operation with its requester ID in a LATENCY-deep shadow pipeline. It returns the product and exception flags on a registered response bus carrying that ID. It sits between the requesting compute units and the multiplier instance, which is instantiated alongside it.

## Interface
- NUM_REQ, default 4: number of requesters; legal range 2..8.
- LATENCY, default 1: multiplier pipeline depth; legal range 1..4; must equal the multiplier's STAGES setting.
- ID_W, derived as max(1, $clog2(NUM_REQ)): width of the requester ID.

- clk  in  1  single clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low; 0 = in reset.
- req_valid  in  NUM_REQ  per-requester operand-pair valid.
- req_ready  out  NUM_REQ  one-hot grant; at most one bit set.
- req_a  in  NUM_REQ*32  operand A; requester i occupies bits [32i+31:32i].
- req_b  in  NUM_REQ*32  operand B; same packing as req_a.
- mul_a  out  32  operand A driven to the multiplier.
- mul_b  out  32  operand B driven to the multiplier.
- mul_result  in  32  product from the multiplier.
- mul_flags  in  3  {exception, overflow, underflow} from the multiplier.
- rsp_valid  out  1  one-cycle response strobe.
- rsp_id  out  ID_W  requester that issued the returning operation.
- rsp_result  out  32  product.
- rsp_flags  out  3  {exception, overflow, underflow}.
- busy  out  1  an operation is in flight or a response is being presented.
- issue_count  out  32  total accepted operations; wraps to 0 after 2^32-1.

## Operation
- **Arbitration** (combinational, each cycle):
  - Search req_valid starting at rr_ptr, wrapping modulo NUM_REQ.
  - The first set bit wins, and req_ready is set for that requester only.
  - No req_valid set: req_ready = 0.
  - While reset = 0: req_ready = 0.
- **Handshake:** a fire occurs when req_valid[i] & req_ready[i].
  - Requesters must hold req_a/req_b stable while req_valid is high and not granted.
  - A requester may deassert req_valid before it is granted; no state is kept for it.
- **Operand drive:** on a fire, mul_a/mul_b carry the granted requester's operands in the same cycle. With no fire, they are driven to 0.
- **rr_ptr** (register, ID_W bits):
  - On a fire by requester g: rr_ptr <= (g+1) mod NUM_REQ.
  - Otherwise rr_ptr holds.
- **Shadow pipeline:** registers vld[0..LATENCY-1] and tag[0..LATENCY-1].
  - vld[0] <= fire and tag[0] <= g. Stage k+1 takes stage k every cycle; there is no stall.
  - Stage LATENCY-1 lines up with a valid mul_result/mul_flags in the same cycle.
- **Response register:** rsp_valid <= vld[LATENCY-1].
  - When vld[LATENCY-1] = 1: rsp_id <= tag[LATENCY-1], rsp_result <= mul_result, rsp_flags <= mul_flags.
  - Otherwise rsp_id, rsp_result and rsp_flags hold their last values.
- **No backpressure on responses:** consumers must accept rsp_valid in the cycle it is high.
- **busy** = OR of all vld bits, OR rsp_valid.
- **issue_count:** increments by 1 on every fire, modulo 2^32.
- **Reset** (asynchronous, also mid-operation):
  - rr_ptr, all vld and tag bits, rsp_valid, rsp_id, rsp_result, rsp_flags and issue_count are cleared to 0.
  - In-flight operations are discarded; no rsp_valid is produced for them after reset release.
  - Multiplier outputs that appear after release are ignored because their vld bits are 0.

## Timing
- Accept rate: one operation per cycle in total, across all requesters.
- Latency: operands fired in cycle c give rsp_valid high in cycle c+LATENCY+1 (LATENCY=1 → 2 cycles, LATENCY=4 → 5 cycles).
- Responses come back in issue order. Back-to-back fires give back-to-back rsp_valid cycles.
- rr_ptr, vld, tag and issue_count update on the edge that ends the fire cycle.
- Combinational paths: req_ready depends on req_valid; mul_a/mul_b depend on req_valid, req_a and req_b. No combinational path from mul_* inputs to any output.
- Fairness: with all NUM_REQ requesters continuously valid, each one is granted exactly once in every NUM_REQ consecutive cycles.

## Test plan
- **Single operation:**
  - Setup: LATENCY=3; req_valid=0001 for one cycle; req0 a=0x40000000 (2.0), b=0x40400000 (3.0).
  - Required: rsp_valid exactly 4 cycles later; rsp_id=0, rsp_result=0x40C00000, rsp_flags=000; issue_count=1; busy high from the cycle after the fire through the rsp_valid cycle.
- **Full contention:**
  - Setup: NUM_REQ=4; all req_valid held high for 8 cycles.
  - Required: grants 0,1,2,3,0,1,2,3; rsp_valid high for 8 consecutive cycles with rsp_id in the same order; issue_count=8.
- **Pointer wrap:**
  - Setup: after one fire by requester 1 (rr_ptr=2), req_valid=1010 is held.
  - Required: grant 3 first, then 1, then 3.
- **Overflow flag:**
  - Setup: a=0x7F7FFFFF, b=0x40000000.
  - Required: rsp_flags overflow bit = 1 on the returning response.
- **Reset mid-operation:**
  - Setup: LATENCY=4; 3 operations in flight; reset pulsed low for 1 cycle.
  - Required: all outputs 0 immediately; no rsp_valid for the next 10 cycles; rr_ptr=0, so the next grant with req_valid=1111 is requester 0.
- **Requester withdrawal:**
  - Setup: req2 valid, but requester 0 is granted first; req2 then drops valid before its grant.
  - Required: requester 2 is never granted; issue_count counts only completed fires.

Source files
------------

// File: rtl/fp_mult_arbiter_if.sv
// ---------------------------------------------------------------------------
// fp_mult_arbiter_if
//   Bundles every bus signal around fp_mult_arbiter: the requester
//   valid/ready/operand lanes, the multiplier operand/result path and the
//   registered response bus. The arbiter connects through the slave modport.
//   The environment connects through the master modport. That environment is
//   the requesting compute units together with the multiplier instance.
//
//   req_valid   NUM_REQ     per-requester operand-pair valid
//   req_ready   NUM_REQ     one-hot grant
//   req_a/b     NUM_REQ*32  operands, requester i at [32i+31:32i]
//   mul_a/b     32          operands driven to the multiplier
//   mul_result  32          product from the multiplier
//   mul_flags   3           {exception, overflow, underflow}
//   rsp_valid   1           one-cycle response strobe
//   rsp_id      ID_W        requester that issued the returning operation
//   rsp_result  32          product
//   rsp_flags   3           {exception, overflow, underflow}
//   busy        1           operation in flight or response presented
//   issue_count 32          total accepted operations (wrapping)
// ---------------------------------------------------------------------------
interface fp_mult_arbiter_if #(
  parameter int NUM_REQ = 4
);
  localparam int ID_W = ($clog2(NUM_REQ) > 1) ? $clog2(NUM_REQ) : 1;

  logic [NUM_REQ-1:0]    req_valid;
  logic [NUM_REQ-1:0]    req_ready;
  logic [NUM_REQ*32-1:0] req_a;
  logic [NUM_REQ*32-1:0] req_b;
  logic [31:0]           mul_a;
  logic [31:0]           mul_b;
  logic [31:0]           mul_result;
  logic [2:0]            mul_flags;
  logic                  rsp_valid;
  logic [ID_W-1:0]       rsp_id;
  logic [31:0]           rsp_result;
  logic [2:0]            rsp_flags;
  logic                  busy;
  logic [31:0]           issue_count;

  modport slave (
    input  req_valid, req_a, req_b, mul_result, mul_flags,
    output req_ready, mul_a, mul_b, rsp_valid, rsp_id, rsp_result,
           rsp_flags, busy, issue_count
  );

  modport master (
    output req_valid, req_a, req_b, mul_result, mul_flags,
    input  req_ready, mul_a, mul_b, rsp_valid, rsp_id, rsp_result,
           rsp_flags, busy, issue_count
  );
endinterface

// File: rtl/fp_mult_arbiter.sv
// ---------------------------------------------------------------------------
// fp_mult_arbiter
//   Round-robin scheduler sharing one pipelined FP multiplier (LATENCY
//   stages, no stall) among NUM_REQ requesters. The winning operand pair is
//   steered to the multiplier in the grant cycle. The requester id travels
//   down a shadow pipeline of the same depth. When it reaches the end, the
//   multiplier output is captured into a registered response tagged with
//   that id.
//
//   clk    rising-edge clock
//   reset  asynchronous, active-low (0 = in reset)
//   bus    fp_mult_arbiter_if.slave (requester lanes, multiplier path,
//          response bus, busy, issue_count)
// ---------------------------------------------------------------------------
module fp_mult_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int LATENCY = 1
) (
  input  logic             clk,
  input  logic             reset,
  fp_mult_arbiter_if.slave bus
);
  localparam int              ID_W      = ($clog2(NUM_REQ) > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [ID_W:0]   NUM_REQ_X = (ID_W+1)'(NUM_REQ);
  localparam logic [ID_W-1:0] LAST_ID   = ID_W'(NUM_REQ-1);

  logic [ID_W-1:0]    r_rr_ptr;
  logic [LATENCY-1:0] r_vld;
  logic [ID_W-1:0]    r_tag [LATENCY];
  logic               r_rsp_valid;
  logic [ID_W-1:0]    r_rsp_id;
  logic [31:0]        r_rsp_result;
  logic [2:0]         r_rsp_flags;
  logic [31:0]        r_issue_count;

  logic [ID_W:0]      w_sum;
  logic [ID_W-1:0]    w_idx;
  logic               w_fire;
  logic [ID_W-1:0]    w_gnt;
  logic [NUM_REQ-1:0] w_ready;
  logic [31:0]        w_a_arr [NUM_REQ];
  logic [31:0]        w_b_arr [NUM_REQ];

  // Round-robin search: visit requesters rr_ptr, rr_ptr+1, ... modulo
  // NUM_REQ and keep the first valid one. Holding reset low masks every
  // grant, so nothing can fire while the block is being cleared.
  always_comb begin
    // NOTE: every variable gets a default before any conditional update so
    // no path leaves it unassigned; otherwise a latch would be inferred.
    w_sum   = '0;
    w_idx   = '0;
    w_fire  = 1'b0;
    w_gnt   = '0;
    w_ready = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      w_sum = {1'b0, r_rr_ptr} + (ID_W+1)'(k);
      if (w_sum >= NUM_REQ_X) w_sum = w_sum - NUM_REQ_X;
      w_idx = w_sum[ID_W-1:0];
      if (!w_fire && reset && bus.req_valid[w_idx]) begin
        w_fire = 1'b1;
        w_gnt  = w_idx;
      end
    end
    if (w_fire) w_ready[w_gnt] = 1'b1;
  end

  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      w_a_arr[i] = bus.req_a[32*i +: 32];
      w_b_arr[i] = bus.req_b[32*i +: 32];
    end
  end

  assign bus.req_ready = w_ready;
  assign bus.mul_a     = w_fire ? w_a_arr[w_gnt] : '0;
  assign bus.mul_b     = w_fire ? w_b_arr[w_gnt] : '0;

  // Pointer moves just past the winner; it only advances on a fire.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_rr_ptr      <= '0;
      r_issue_count <= '0;
    end else if (w_fire) begin
      r_rr_ptr      <= (w_gnt == LAST_ID) ? '0 : w_gnt + 1'b1;
      r_issue_count <= r_issue_count + 32'd1;
    end
  end

  // Shadow pipeline: id of each issued operation, aligned with the
  // multiplier so stage LATENCY-1 meets its valid result.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_vld <= '0;
      // NOTE: the tag array is cleared along with vld so that in-flight ids
      // are discarded and rsp_id reads 0 after reset.
      for (int k = 0; k < LATENCY; k++) r_tag[k] <= '0;
    end else begin
      r_vld[0] <= w_fire;
      r_tag[0] <= w_gnt;
      for (int k = 1; k < LATENCY; k++) begin
        r_vld[k] <= r_vld[k-1];
        r_tag[k] <= r_tag[k-1];
      end
    end
  end

  // Response register: payload is captured only for a valid operation and
  // otherwise holds, so consumers may still read it after the strobe.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_rsp_valid  <= 1'b0;
      r_rsp_id     <= '0;
      r_rsp_result <= '0;
      r_rsp_flags  <= '0;
    end else begin
      r_rsp_valid <= r_vld[LATENCY-1];
      if (r_vld[LATENCY-1]) begin
        r_rsp_id     <= r_tag[LATENCY-1];
        r_rsp_result <= bus.mul_result;
        r_rsp_flags  <= bus.mul_flags;
      end
    end
  end

  assign bus.rsp_valid   = r_rsp_valid;
  assign bus.rsp_id      = r_rsp_id;
  assign bus.rsp_result  = r_rsp_result;
  assign bus.rsp_flags   = r_rsp_flags;
  assign bus.busy        = (|r_vld) | r_rsp_valid;
  assign bus.issue_count = r_issue_count;
endmodule
